// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Bundles the fetch sequencer's control inputs (run, MFC,
//                exec_done, trap_ack) and its datapath enables/selects,
//                handshake flags and performance counters.
//                master : fetch sequencer side (drives enables/selects)
//                slave  : datapath / RAM / decode-execute side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
    // Control inputs to the sequencer
    logic        run;
    logic        MFC;
    logic        exec_done;
    logic        trap_ack;

    // Datapath enables and selects
    logic        MARE;
    logic [1:0]  MAR_SEL;
    logic        MFA;
    logic        MOP_SEL;
    logic [5:0]  OP1;
    logic        MDRE;
    logic [1:0]  MDR_SEL;
    logic        IRE;
    logic        PCE;
    logic        nPCE;
    logic [1:0]  nPC_SEL;
    logic        nPC_ADD;
    logic        nPC_ADDSEL;
    logic        tQE;
    logic [5:0]  tQ_IN;

    // Handshake / status
    logic        ir_valid;
    logic        fault;

    // Performance counters
    logic [31:0] fetch_count;
    logic [31:0] wait_count;

    modport master (
        input  run, MFC, exec_done, trap_ack,
        output MARE, MAR_SEL, MFA, MOP_SEL, OP1, MDRE, MDR_SEL,
               IRE, PCE, nPCE, nPC_SEL, nPC_ADD, nPC_ADDSEL,
               tQE, tQ_IN, ir_valid, fault, fetch_count, wait_count
    );

    modport slave (
        output run, MFC, exec_done, trap_ack,
        input  MARE, MAR_SEL, MFA, MOP_SEL, OP1, MDRE, MDR_SEL,
               IRE, PCE, nPCE, nPC_SEL, nPC_ADD, nPC_ADDSEL,
               tQE, tQ_IN, ir_valid, fault, fetch_count, wait_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch control FSM upstream of the SPARC datapath.
//                Sequences MAR load, memory read request (with no-response
//                timeout), MDR/IR load and PC/nPC advance, then holds the
//                instruction (ir_valid) until exec_done. A timeout raises an
//                instruction-access trap (tQE with FAULT_TT) and waits in a
//                fault state for trap_ack.
//  Ports       : Clk    - system clock, rising edge
//                Reset  - synchronous active-high reset
//                bus    - fetch_sequencer_if.master (inputs run, MFC,
//                         exec_done, trap_ack; all enables/selects, ir_valid,
//                         fault, fetch_count, wait_count)
//  Options     : FETCH_PERF_EN - when defined, fetch_count/wait_count are
//                real counters; otherwise both are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned TIMEOUT  = 16,      // 2..255 REQ cycles before fault
    parameter logic [5:0]  LD_OP    = 6'b000000,
    parameter logic [5:0]  FAULT_TT = 6'h01
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAR   = 3'd1,
        ST_REQ   = 3'd2,
        ST_IR    = 3'd3,
        ST_PC    = 3'd4,
        ST_HAND  = 3'd5,
        ST_TRAP  = 3'd6,
        ST_FWAIT = 3'd7
    } state_t;

    // Last REQ cycle index before the timeout fires (timer counts 0..TIMEOUT-1)
    localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;

    // Registered Moore outputs, loaded from the decode of the next state so
    // they line up exactly with r_state.
    logic       r_mare;
    logic [1:0] r_mar_sel;
    logic       r_mfa;
    logic       r_mop_sel;
    logic       r_ire;
    logic       r_pce;
    logic       r_npce;
    logic       r_npc_add;
    logic       r_tqe;
    logic       r_ir_valid;
    logic       r_fault;

    // ------------------------------------------------------------------
    // Next-state and timer logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = r_timer;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = bus.run ? ST_MAR : ST_IDLE;
            end
            ST_MAR: begin
                w_state_nxt = ST_REQ;
                w_timer_nxt = 8'd0;
            end
            ST_REQ: begin
                // MFC takes priority over the timeout on the final cycle
                if (bus.MFC) begin
                    w_state_nxt = ST_IR;
                end else if (r_timer == c_timer_last) begin
                    w_state_nxt = ST_TRAP;
                end else begin
                    w_state_nxt = ST_REQ;
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            ST_IR: begin
                w_state_nxt = ST_PC;
            end
            ST_PC: begin
                w_state_nxt = ST_HAND;
            end
            ST_HAND: begin
                if (bus.exec_done) begin
                    w_state_nxt = bus.run ? ST_MAR : ST_IDLE;
                end else begin
                    w_state_nxt = ST_HAND;
                end
            end
            ST_TRAP: begin
                w_state_nxt = ST_FWAIT;
            end
            ST_FWAIT: begin
                if (bus.trap_ack) begin
                    w_state_nxt = bus.run ? ST_MAR : ST_IDLE;
                end else begin
                    w_state_nxt = ST_FWAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, timer and registered output flops
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= 8'd0;
            r_mare     <= 1'b0;
            r_mar_sel  <= 2'b00;
            r_mfa      <= 1'b0;
            r_mop_sel  <= 1'b0;
            r_ire      <= 1'b0;
            r_pce      <= 1'b0;
            r_npce     <= 1'b0;
            r_npc_add  <= 1'b0;
            r_tqe      <= 1'b0;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_mare     <= (w_state_nxt == ST_MAR);
            r_mar_sel  <= (w_state_nxt == ST_MAR) ? 2'b01 : 2'b00;
            r_mfa      <= (w_state_nxt == ST_REQ);
            r_mop_sel  <= (w_state_nxt == ST_REQ);
            r_ire      <= (w_state_nxt == ST_IR);
            r_pce      <= (w_state_nxt == ST_PC);
            r_npce     <= (w_state_nxt == ST_PC);
            r_npc_add  <= (w_state_nxt == ST_PC);
            r_tqe      <= (w_state_nxt == ST_TRAP);
            r_ir_valid <= (w_state_nxt == ST_HAND);
            r_fault    <= (w_state_nxt == ST_FWAIT);
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.MARE       = r_mare;
    assign bus.MAR_SEL    = r_mar_sel;
    assign bus.MFA        = r_mfa;
    assign bus.MOP_SEL    = r_mop_sel;
    assign bus.OP1        = LD_OP;
    // MDR captures the RAM word only in the REQ cycle where MFC arrives
    assign bus.MDRE       = (r_state == ST_REQ) && bus.MFC;
    assign bus.MDR_SEL    = 2'b00;
    assign bus.IRE        = r_ire;
    assign bus.PCE        = r_pce;
    assign bus.nPCE       = r_npce;
    // nPC mux selects the adder path, adder adds +4: PC<-nPC, nPC<-nPC+4
    assign bus.nPC_SEL    = 2'b00;
    assign bus.nPC_ADD    = r_npc_add;
    assign bus.nPC_ADDSEL = 1'b0;
    assign bus.tQE        = r_tqe;
    assign bus.tQ_IN      = FAULT_TT;
    assign bus.ir_valid   = r_ir_valid;
    assign bus.fault      = r_fault;

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_wait_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fetch_count <= 32'd0;
            r_wait_count  <= 32'd0;
        end else begin
            // IR always proceeds to PC, so an IR cycle is a completed fetch
            if (r_state == ST_IR) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if ((r_state == ST_REQ) && !bus.MFC) begin
                r_wait_count <= r_wait_count + 32'd1;
            end
        end
    end

    assign bus.fetch_count = r_fetch_count;
    assign bus.wait_count  = r_wait_count;
`else
    assign bus.fetch_count = 32'd0;
    assign bus.wait_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A table of per-cycle
//                input/expected-output records covers the basic fetch paths;
//                hand-written sequences cover timeout, MFC on the last REQ
//                cycle, reset mid-fetch and back-to-back fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic Clk;
    logic Reset;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .TIMEOUT  (16),
        .LD_OP    (6'b000000),
        .FAULT_TT (6'h01)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Observed vector bit order:
    // {MARE, MAR_SEL[1:0], MFA, MOP_SEL, MDRE, MDR_SEL[1:0], IRE, PCE, nPCE,
    //  nPC_SEL[1:0], nPC_ADD, nPC_ADDSEL, tQE, ir_valid, fault}
    localparam logic [17:0] O_IDLE  = 18'b0_00_0_0_0_00_0_0_0_00_0_0_0_0_0;
    localparam logic [17:0] O_MAR   = 18'b1_01_0_0_0_00_0_0_0_00_0_0_0_0_0;
    localparam logic [17:0] O_REQ   = 18'b0_00_1_1_0_00_0_0_0_00_0_0_0_0_0;
    localparam logic [17:0] O_REQM  = 18'b0_00_1_1_1_00_0_0_0_00_0_0_0_0_0;
    localparam logic [17:0] O_IR    = 18'b0_00_0_0_0_00_1_0_0_00_0_0_0_0_0;
    localparam logic [17:0] O_PC    = 18'b0_00_0_0_0_00_0_1_1_00_1_0_0_0_0;
    localparam logic [17:0] O_HAND  = 18'b0_00_0_0_0_00_0_0_0_00_0_0_0_1_0;
    localparam logic [17:0] O_TRAP  = 18'b0_00_0_0_0_00_0_0_0_00_0_0_1_0_0;
    localparam logic [17:0] O_FWAIT = 18'b0_00_0_0_0_00_0_0_0_00_0_0_0_0_1;

    typedef struct {
        logic        run;
        logic        mfc;
        logic        ed;
        logic        ta;
        logic [17:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic logic [17:0] obs();
        return {bus.MARE, bus.MAR_SEL, bus.MFA, bus.MOP_SEL, bus.MDRE,
                bus.MDR_SEL, bus.IRE, bus.PCE, bus.nPCE, bus.nPC_SEL,
                bus.nPC_ADD, bus.nPC_ADDSEL, bus.tQE, bus.ir_valid, bus.fault};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, let them settle, compare the outputs of
    // the current state, then advance to just after the next rising edge.
    task automatic cyc(input logic r, input logic m, input logic e, input logic t,
                       input logic [17:0] exp, input string nm);
        bus.run       = r;
        bus.MFC       = m;
        bus.exec_done = e;
        bus.trap_ack  = t;
        #1;
        chk(nm, {14'd0, obs()}, {14'd0, exp});
        @(posedge Clk);
        #1;
    endtask

    vec_t tbl [28];

    initial begin
        // Immediate MFC; exec_done ignored in IR; run dropped in HAND
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_MAR};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, O_REQM};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, O_IR};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_PC};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_HAND};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_HAND};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, O_HAND};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
        // MFC delayed 3 cycles; MFC ignored in MAR; trap_ack ignored in REQ
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, O_MAR};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, O_REQ};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, O_REQ};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, O_REQ};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, O_REQM};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, O_IR};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, O_PC};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, O_HAND};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, O_HAND};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
        // run dropped mid-fetch: fetch completes, then back to IDLE, no MARE
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, O_MAR};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b0, O_REQM};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, O_IR};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, O_PC};
        tbl[25] = '{1'b0, 1'b0, 1'b1, 1'b0, O_HAND};
        tbl[26] = '{1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[27] = '{1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};

        // ---------------- Reset state ----------------
        Reset         = 1'b1;
        bus.run       = 1'b0;
        bus.MFC       = 1'b0;
        bus.exec_done = 1'b0;
        bus.trap_ack  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_outputs", {14'd0, obs()}, {14'd0, O_IDLE});
        chk("reset_op1",     {26'd0, bus.OP1},   32'h0);
        chk("reset_tq_in",   {26'd0, bus.tQ_IN}, 32'h1);
        chk("reset_fetch_count", bus.fetch_count, 32'd0);
        chk("reset_wait_count",  bus.wait_count,  32'd0);
        Reset = 1'b0;

        // ---------------- Table-driven vectors ----------------
        for (int i = 0; i < 28; i++) begin
            cyc(tbl[i].run, tbl[i].mfc, tbl[i].ed, tbl[i].ta, tbl[i].exp,
                $sformatf("tbl[%0d]", i));
        end
`ifdef FETCH_PERF_EN
        chk("tbl_fetch_count", bus.fetch_count, 32'd3);
        chk("tbl_wait_count",  bus.wait_count,  32'd3);
`else
        chk("tbl_fetch_count", bus.fetch_count, 32'd0);
        chk("tbl_wait_count",  bus.wait_count,  32'd0);
`endif

        // ---------------- Timeout: MFC never arrives ----------------
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE, "to_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_MAR,  "to_mar");
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, O_REQ, $sformatf("to_req%0d", i));
        end
        bus.MFC = 1'b0;
        #1;
        chk("to_tq_in", {26'd0, bus.tQ_IN}, 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_TRAP,  "to_trap");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, O_FWAIT, "to_fwait0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_FWAIT, "to_fwait1");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, O_FWAIT, "to_fwait_ack");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_MAR,   "to_ack_mar");

        // ---------------- MFC on the 16th REQ cycle wins ----------------
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, O_REQ, $sformatf("last_req%0d", i));
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, O_REQM, "last_req15_mfc");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_IR,   "last_ir");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_PC,   "last_pc");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, O_HAND, "last_hand");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, "last_idle");
`ifdef FETCH_PERF_EN
        chk("last_fetch_count", bus.fetch_count, 32'd4);
        chk("last_wait_count",  bus.wait_count,  32'd34);
`else
        chk("last_fetch_count", bus.fetch_count, 32'd0);
        chk("last_wait_count",  bus.wait_count,  32'd0);
`endif

        // ---------------- Reset mid-REQ with MFA high ----------------
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE, "rst_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_MAR,  "rst_mar");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_REQ,  "rst_req0");
        Reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, O_REQM, "rst_req1");
        Reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, "rst_after");
        chk("rst_fetch_count", bus.fetch_count, 32'd0);
        chk("rst_wait_count",  bus.wait_count,  32'd0);

        // ---------------- Back-to-back fetches ----------------
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE, "b2b_idle");
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, O_MAR,  $sformatf("b2b%0d_mar", k));
            cyc(1'b1, 1'b1, 1'b0, 1'b0, O_REQM, $sformatf("b2b%0d_req", k));
            cyc(1'b1, 1'b0, 1'b0, 1'b0, O_IR,   $sformatf("b2b%0d_ir", k));
            cyc(1'b1, 1'b0, 1'b0, 1'b0, O_PC,   $sformatf("b2b%0d_pc", k));
            cyc((k < 2) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0, O_HAND,
                $sformatf("b2b%0d_hand", k));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, "b2b_end");
`ifdef FETCH_PERF_EN
        chk("b2b_fetch_count", bus.fetch_count, 32'd3);
`else
        chk("b2b_fetch_count", bus.fetch_count, 32'd0);
`endif
        chk("b2b_wait_count", bus.wait_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
